// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, ALU operation encodings, the decoded-bundle
// struct and the pure combinational RV32I decode helper shared by the stage.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Width of the alu_op field carried inside the bundle; the stage output is
  // resized to its ALU_OP_W parameter.
  localparam int ALU_OP_PKG_W = 4;

  // ALU operation codes are {funct7[5], funct3}.
  typedef enum logic [ALU_OP_PKG_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef struct packed {
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    reg_write;
    logic [31:0]             imm;
    logic [ALU_OP_PKG_W-1:0] alu_op;
    logic                    use_imm;
    logic                    illegal;
  } decode_bundle_t;

  // Unused source fields are left at 0 so x0 can never raise a hazard.
  function automatic decode_bundle_t decode_instr(input logic [31:0] instr);
    decode_bundle_t b;
    b = '0;
    case (instr[6:0])
      OPC_OP: begin
        b.rs1       = instr[19:15];
        b.rs2       = instr[24:20];
        b.rd        = instr[11:7];
        b.alu_op    = {instr[30], instr[14:12]};
        b.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        b.rs1       = instr[19:15];
        b.rd        = instr[11:7];
        b.imm       = {{20{instr[31]}}, instr[31:20]};
        b.alu_op    = {(instr[14:12] == 3'b101) & instr[30], instr[14:12]};
        b.use_imm   = 1'b1;
        b.reg_write = 1'b1;
      end
      OPC_LUI: begin
        b.rd        = instr[11:7];
        b.imm       = {instr[31:12], 12'b0};
        b.alu_op    = ALU_ADD;
        b.use_imm   = 1'b1;
        b.reg_write = 1'b1;
      end
      default: begin
        b.illegal = 1'b1;
      end
    endcase
    if (b.rd == 5'd0) b.reg_write = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// decode_scoreboard: busy bit per architectural register. One set port
// (issue), one clear port (writeback retire) and two lookup ports.
// A coincident set and clear of the same bit leaves it set; bit 0 is never set.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en_i,
  input  logic [4:0] set_rd_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_rd_i,
  input  logic [4:0] look_a_i,
  input  logic [4:0] look_b_i,
  output logic       busy_a_o,
  output logic       busy_b_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy vector: clear first, then set, so a set wins on a collision.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (clr_en_i && (clr_rd_i == 5'(i))) busy_d[i] = 1'b0;
      if (set_en_i && (set_rd_i == 5'(i))) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Lookups see registered state only; no bypass of a same-cycle clear.
  always_comb begin
    busy_a_o = 1'b0;
    busy_b_o = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (look_a_i == 5'(i)) busy_a_o = busy_q[i];
      if (look_b_i == 5'(i)) busy_b_o = busy_q[i];
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-entry RV32I decode (OP, OP-IMM, LUI) with a
// valid/ready handshake on both sides and a one-cycle registered output.
// Build option DECODE_SCOREBOARD_EN adds a register busy scoreboard that
// stalls instructions reading a register with a pending write.
module decode_stage
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_reg_write,
  output logic [31:0]         out_imm,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_use_imm,
  output logic                out_illegal,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd
);

  decode_bundle_t dec;
  decode_bundle_t bundle_q;
  logic           out_valid_q;
  logic           hazard;
  logic           xfer;

  assign dec = decode_instr(instr);

`ifdef DECODE_SCOREBOARD_EN
  logic busy_a, busy_b;

  decode_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en_i (xfer && dec.reg_write),
    .set_rd_i (dec.rd),
    .clr_en_i (wb_valid),
    .clr_rd_i (wb_rd),
    .look_a_i (dec.rs1),
    .look_b_i (dec.rs2),
    .busy_a_o (busy_a),
    .busy_b_o (busy_b)
  );

  assign hazard = busy_a | busy_b;
`else
  // Writeback notifications are meaningless without the scoreboard.
  logic unused_wb;
  localparam int unused_num_regs = NUM_REGS;
  assign unused_wb = ^{wb_valid, wb_rd};
  assign hazard    = 1'b0;
`endif

  assign in_ready = !reset && (!out_valid_q || out_ready) && !hazard;
  assign xfer     = in_valid && in_ready;

  // Output register: load on transfer, drop valid once consumed, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      bundle_q    <= dec;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_rd        = bundle_q.rd;
  assign out_reg_write = bundle_q.reg_write;
  assign out_imm       = bundle_q.imm;
  assign out_alu_op    = ALU_OP_W'(bundle_q.alu_op);
  assign out_use_imm   = bundle_q.use_imm;
  assign out_illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by randomized traffic, all
// compared against an arithmetic reference model of the decode rules,
// the handshake and the register busy set.
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_reg_write;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_use_imm;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  decode_stage #(.NUM_REGS(32), .ALU_OP_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .out_imm      (out_imm),
    .out_alu_op   (out_alu_op),
    .out_use_imm  (out_use_imm),
    .out_illegal  (out_illegal),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rs1, rs2, rd;
    bit          rw;
    logic [31:0] imm;
    int unsigned op;
    bit          ui;
    bit          ill;
    bit          use1, use2;
  } ref_t;

  // Reference model state
  bit   m_valid;
  ref_t m_b;
  bit   m_busy [32];

  // Field extraction by plain arithmetic on the instruction word.
  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int unsigned u;
    int unsigned opc, rd, f3, rs1, rs2, b30;
    int s;
    u   = w;
    opc = u % 128;
    rd  = (u / 128) % 32;
    f3  = (u / 4096) % 8;
    rs1 = (u / 32768) % 32;
    rs2 = (u / 1048576) % 32;
    b30 = (u / 1073741824) % 2;
    s   = $signed(w);
    r   = '{rs1: 0, rs2: 0, rd: 0, rw: 0, imm: 32'd0, op: 0, ui: 0, ill: 0, use1: 0, use2: 0};
    if (opc == 51) begin
      r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = 1;
      r.op = b30 * 8 + f3; r.use1 = 1; r.use2 = 1;
    end else if (opc == 19) begin
      r.rs1 = rs1; r.rd = rd; r.rw = 1; r.ui = 1; r.use1 = 1;
      r.imm = 32'(s >>> 20);
      r.op  = ((f3 == 5) ? b30 * 8 : 0) + f3;
    end else if (opc == 55) begin
      r.rd = rd; r.rw = 1; r.ui = 1;
      r.imm = 32'(u - (u % 4096));
    end else begin
      r.ill = 1;
    end
    if (r.rd == 0) r.rw = 0;
    return r;
  endfunction

  function automatic bit exp_ready();
    ref_t c;
    bit   hz;
    c  = ref_decode(instr);
    hz = SB_EN && ((c.use1 && m_busy[c.rs1]) || (c.use2 && m_busy[c.rs2]));
    return !reset && (!m_valid || out_ready) && !hz;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_b = ref_decode(32'd0);
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rs1", 32'(out_rs1), m_b.rs1);
      chk("rs2", 32'(out_rs2), m_b.rs2);
      chk("rd", 32'(out_rd), m_b.rd);
      chk("reg_write", 32'(out_reg_write), 32'(m_b.rw));
      chk("imm", out_imm, m_b.imm);
      chk("alu_op", 32'(out_alu_op), m_b.op);
      chk("use_imm", 32'(out_use_imm), 32'(m_b.ui));
      chk("illegal", 32'(out_illegal), 32'(m_b.ill));
    end
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_edge();
    bit   xf;
    ref_t c;
    c  = ref_decode(instr);
    xf = in_valid && exp_ready();
    if (SB_EN && wb_valid) m_busy[wb_rd] = 0;
    if (xf && c.rw) m_busy[c.rd] = 1;
    if (xf) begin
      m_valid = 1;
      m_b = c;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned kind, rd, rs1, rs2, f3, f7, imm;
    kind = $urandom_range(0, 9);
    rd   = $urandom_range(0, 7);
    rs1  = $urandom_range(0, 7);
    rs2  = $urandom_range(0, 7);
    f3   = $urandom_range(0, 7);
    f7   = ($urandom_range(0, 1) != 0) ? 32 : 0;
    imm  = $urandom_range(0, 4095);
    if (kind <= 3)
      return 32'(f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51);
    else if (kind <= 6)
      return 32'(imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19);
    else if (kind == 7)
      return 32'($urandom_range(0, 1048575) * 4096 + rd * 128 + 55);
    else
      return $urandom();
  endfunction

  initial begin
    reset = 1; in_valid = 0; instr = 0; out_ready = 1; wb_valid = 0; wb_rd = 0;
    model_reset();

    // Reset state
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_imm", out_imm, 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // add x0,x1,x2: accepted, one cycle later visible, rd=0 suppresses write
    in_valid = 1; instr = 32'h00208033;
    tick();
    chk("d_add_valid", 32'(out_valid), 1);
    chk("d_add_rs1", 32'(out_rs1), 1);
    chk("d_add_rs2", 32'(out_rs2), 2);
    chk("d_add_rd", 32'(out_rd), 0);
    chk("d_add_rw", 32'(out_reg_write), 0);

    // addi x5,x0,-1
    instr = 32'hFFF00293;
    tick();
    in_valid = 0;
    chk("d_addi_imm", out_imm, 32'hFFFFFFFF);
    chk("d_addi_rd", 32'(out_rd), 5);
    chk("d_addi_ui", 32'(out_use_imm), 1);
    chk("d_addi_rw", 32'(out_reg_write), 1);

    // add x6,x5,x5 stalls on busy x5 until the cycle after its writeback
    in_valid = 1; instr = 32'h00528333;
    #1;
    chk("d_haz_stall", 32'(in_ready), 32'(exp_ready()));
    tick(); tick(); tick();
    wb_valid = 1; wb_rd = 5;
    tick();
    wb_valid = 0;
    chk("d_haz_release", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    chk("d_add6_rd", 32'(out_rd), 6);
    chk("d_add6_rs1", 32'(out_rs1), 5);

    // Output hold under backpressure
    tick();
    in_valid = 1; instr = 32'h00300393; out_ready = 0;
    tick();
    instr = 32'h12345437;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_hold_valid", 32'(out_valid), 1);
      chk("d_hold_imm", out_imm, 3);
      chk("d_hold_rd", 32'(out_rd), 7);
      chk("d_hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("d_lui_rd", 32'(out_rd), 8);
    chk("d_lui_imm", out_imm, 32'h12345000);
    chk("d_lui_alu", 32'(out_alu_op), 0);
    chk("d_lui_ui", 32'(out_use_imm), 1);

    // JAL is illegal
    tick();
    in_valid = 1; instr = 32'h0000006F;
    tick();
    in_valid = 0;
    chk("d_jal_ill", 32'(out_illegal), 1);
    chk("d_jal_rw", 32'(out_reg_write), 0);
    chk("d_jal_rd", 32'(out_rd), 0);
    chk("d_jal_imm", out_imm, 0);

    // Reset while a bundle is held and x5 is busy
    tick();
    in_valid = 1; instr = 32'hFFF00293; out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    reset = 1;
    #2;
    chk("d_mrst_valid", 32'(out_valid), 0);
    chk("d_mrst_in_ready", 32'(in_ready), 0);
    chk("d_mrst_rd", 32'(out_rd), 0);
    chk("d_mrst_imm", out_imm, 0);
    chk("d_mrst_rw", 32'(out_reg_write), 0);
    model_reset();
    out_ready = 1;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    in_valid = 1; instr = 32'h00528333;
    #1;
    chk("d_mrst_busy_clear", 32'(in_ready), 1);
    tick();
    in_valid = 0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      tick();
    end
    in_valid = 0; wb_valid = 0; out_ready = 1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
